// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I widths, register index/data types and zero-register constant
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    // A write retires only when enabled and not aimed at the hardwired zero register.
    function automatic logic is_commit(input logic we, input reg_addr_t rd);
        return we && (rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/rv32_regfile_if.sv
// rtl/rv32_regfile_if.sv - register file bus: write port, rs1/rs2/debug read ports, commit trace
//
// master : core side (drives write/read indices, consumes read data and trace)
// slave  : register file side
interface rv32_regfile_if;
    import rv32_pkg::*;

    logic        reg_write;
    reg_addr_t   rd_addr;
    xlen_t       wb_data;
    reg_addr_t   rs1_addr;
    reg_addr_t   rs2_addr;
    xlen_t       rs1_data;
    xlen_t       rs2_data;
    reg_addr_t   dbg_addr;
    xlen_t       dbg_data;
    logic        trace_valid;
    reg_addr_t   trace_rd;
    xlen_t       trace_data;
    logic [31:0] wr_count;

    modport master (
        output reg_write, rd_addr, wb_data, rs1_addr, rs2_addr, dbg_addr,
        input  rs1_data, rs2_data, dbg_data, trace_valid, trace_rd, trace_data, wr_count
    );

    modport slave (
        input  reg_write, rd_addr, wb_data, rs1_addr, rs2_addr, dbg_addr,
        output rs1_data, rs2_data, dbg_data, trace_valid, trace_rd, trace_data, wr_count
    );

endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational register read port with x0 forcing and bypass mux
//
// Ports:
//   addr      in   read index
//   regs      in   flattened register storage
//   byp_valid in   a commit is in flight this cycle (tie 0 to disable bypass)
//   byp_addr  in   index of the in-flight commit
//   byp_data  in   value of the in-flight commit
//   data      out  read value
module regfile_read_port
    import rv32_pkg::*;
(
    input  reg_addr_t                   addr,
    input  logic [NREGS-1:0][XLEN-1:0]  regs,
    input  logic                        byp_valid,
    input  reg_addr_t                   byp_addr,
    input  xlen_t                       byp_data,
    output xlen_t                       data
);

    always_comb begin
        data = regs[addr];
        // byp_valid is only ever asserted for non-zero rd, but x0 forcing
        // is kept last so that index 0 reads zero unconditionally.
        if (byp_valid && (byp_addr == addr)) begin
            data = byp_data;
        end
        if (addr == ZERO_REG) begin
            data = '0;
        end
    end

endmodule

// File: rtl/rv32_regfile.sv
// rtl/rv32_regfile.sv - RV32I architectural register file with commit trace and write counter
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   rf     slave modport of rv32_regfile_if (write port, rs1/rs2/debug reads, trace, wr_count)
//
// Build option: REGFILE_BYPASS_EN makes rs1/rs2 write-through for a same-cycle
// commit to the register being read. The debug port never bypasses.
module rv32_regfile
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    rv32_regfile_if.slave   rf
);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic                       trace_valid_q;
    reg_addr_t                  trace_rd_q;
    xlen_t                      trace_data_q;
    logic [31:0]                wr_count_q;

    logic commit;
    logic byp_valid;

    assign commit = is_commit(rf.reg_write, rf.rd_addr);

`ifdef REGFILE_BYPASS_EN
    // Gated by rst_n so source reads stay zero while reset is held.
    assign byp_valid = commit & rst_n;
`else
    assign byp_valid = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q        <= '0;
            trace_valid_q <= 1'b0;
            trace_rd_q    <= '0;
            trace_data_q  <= '0;
            wr_count_q    <= '0;
        end else begin
            trace_valid_q <= commit;
            if (commit) begin
                regs_q[rf.rd_addr] <= rf.wb_data;
                trace_rd_q         <= rf.rd_addr;
                trace_data_q       <= rf.wb_data;
                wr_count_q         <= wr_count_q + 32'd1;
            end
        end
    end

    regfile_read_port u_rs1_port (
        .addr      (rf.rs1_addr),
        .regs      (regs_q),
        .byp_valid (byp_valid),
        .byp_addr  (rf.rd_addr),
        .byp_data  (rf.wb_data),
        .data      (rf.rs1_data)
    );

    regfile_read_port u_rs2_port (
        .addr      (rf.rs2_addr),
        .regs      (regs_q),
        .byp_valid (byp_valid),
        .byp_addr  (rf.rd_addr),
        .byp_data  (rf.wb_data),
        .data      (rf.rs2_data)
    );

    regfile_read_port u_dbg_port (
        .addr      (rf.dbg_addr),
        .regs      (regs_q),
        .byp_valid (1'b0),
        .byp_addr  (rf.rd_addr),
        .byp_data  (rf.wb_data),
        .data      (rf.dbg_data)
    );

    assign rf.trace_valid = trace_valid_q;
    assign rf.trace_rd    = trace_rd_q;
    assign rf.trace_data  = trace_data_q;
    assign rf.wr_count    = wr_count_q;

endmodule

// File: tb/tb_rv32_regfile.sv
// tb/tb_rv32_regfile.sv - scoreboard bench for rv32_regfile with directed vectors
module tb_rv32_regfile;

    localparam int SEL_RS1  = 0;
    localparam int SEL_RS2  = 1;
    localparam int SEL_DBG  = 2;
    localparam int SEL_CNT  = 3;
    localparam int SEL_TV   = 4;
    localparam int SEL_TRD  = 5;
    localparam int SEL_TDAT = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] cnt;
    } tr_t;

    logic clk;
    logic rst_n;

    chk_t chk_q[$];
    tr_t  tr_q[$];

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_cnt = 32'd0;

    rv32_regfile_if rf_if ();

    rv32_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sel_val(input int sel);
        case (sel)
            SEL_RS1:  return rf_if.rs1_data;
            SEL_RS2:  return rf_if.rs2_data;
            SEL_DBG:  return rf_if.dbg_data;
            SEL_CNT:  return rf_if.wr_count;
            SEL_TV:   return {31'd0, rf_if.trace_valid};
            SEL_TRD:  return {27'd0, rf_if.trace_rd};
            default:  return rf_if.trace_data;
        endcase
    endfunction

    task automatic chk(input string name, input int sel, input logic [31:0] exp);
        chk_q.push_back('{name, sel, exp});
    endtask

    // Drives the write port; a real commit also books its expected trace.
    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d);
        rf_if.reg_write = we;
        rf_if.rd_addr   = rd;
        rf_if.wb_data   = d;
        if (we && rd != 5'd0) begin
            exp_cnt = exp_cnt + 32'd1;
            tr_q.push_back('{rd, d, exp_cnt});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares queued read checks and every trace pulse at the falling edge.
    always @(negedge clk) begin
        chk_t        c;
        tr_t         t;
        logic [31:0] act;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            act = sel_val(c.sel);
            tests++;
            if (act !== c.exp) begin
                fails++;
                $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
            end
        end
        if (rf_if.trace_valid === 1'b1) begin
            tests++;
            if (tr_q.size() == 0) begin
                fails++;
                $display("FAIL trace_unexpected: got rd=%0d data=%08h expected no pulse",
                         rf_if.trace_rd, rf_if.trace_data);
            end else begin
                t = tr_q.pop_front();
                if (rf_if.trace_rd !== t.rd || rf_if.trace_data !== t.data ||
                    rf_if.wr_count !== t.cnt) begin
                    fails++;
                    $display("FAIL trace: got rd=%0d data=%08h cnt=%08h expected rd=%0d data=%08h cnt=%08h",
                             rf_if.trace_rd, rf_if.trace_data, rf_if.wr_count, t.rd, t.data, t.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        rf_if.reg_write = 1'b0;
        rf_if.rd_addr   = 5'd0;
        rf_if.wb_data   = 32'd0;
        rf_if.rs1_addr  = 5'd1;
        rf_if.rs2_addr  = 5'd31;
        rf_if.dbg_addr  = 5'd1;
        #2;
        chk("reset_cnt",  SEL_CNT,  32'd0);
        chk("reset_tv",   SEL_TV,   32'd0);
        chk("reset_trd",  SEL_TRD,  32'd0);
        chk("reset_tdat", SEL_TDAT, 32'd0);
        chk("reset_rs1",  SEL_RS1,  32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Basic write/read on consecutive edges
        drive(1'b1, 5'd1, 32'hAAAA_AAAA);
        step();
        drive(1'b1, 5'd31, 32'hBBBB_BBBB);
        step();
        drive(1'b0, 5'd0, 32'd0);
        rf_if.rs1_addr = 5'd1;
        rf_if.rs2_addr = 5'd31;
        chk("basic_rs1", SEL_RS1, 32'hAAAA_AAAA);
        chk("basic_rs2", SEL_RS2, 32'hBBBB_BBBB);
        chk("basic_cnt", SEL_CNT, 32'd2);
        step();

        // Write to x0 is discarded
        drive(1'b1, 5'd0, 32'hDEAD_BEEF);
        rf_if.rs1_addr = 5'd0;
        rf_if.dbg_addr = 5'd0;
        chk("x0_rs1_same", SEL_RS1, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("x0_rs1",   SEL_RS1, 32'd0);
        chk("x0_dbg",   SEL_DBG, 32'd0);
        chk("x0_tv",    SEL_TV,  32'd0);
        chk("x0_cnt",   SEL_CNT, 32'd2);
        step();

        // Same-cycle read of the register being written
        drive(1'b1, 5'd7, 32'h1111_1111);
        step();
        drive(1'b1, 5'd7, 32'h2222_2222);
        rf_if.rs1_addr = 5'd7;
        rf_if.dbg_addr = 5'd7;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_rs1", SEL_RS1, 32'h2222_2222);
`else
        chk("same_cycle_rs1", SEL_RS1, 32'h1111_1111);
`endif
        chk("same_cycle_dbg", SEL_DBG, 32'h1111_1111);
        step();
        drive(1'b0, 5'd0, 32'd0);
        rf_if.rs2_addr = 5'd7;
        chk("after_write_rs1", SEL_RS1, 32'h2222_2222);
        chk("after_write_rs2", SEL_RS2, 32'h2222_2222);
        step();

        // Hold: trace fields keep the last commit (x9) while x3 is not written
        drive(1'b1, 5'd3, 32'h0000_0033);
        step();
        drive(1'b1, 5'd9, 32'h0000_0099);
        step();
        drive(1'b0, 5'd3, 32'h0000_0044);
        rf_if.rs2_addr = 5'd3;
        chk("hold_rs2_same", SEL_RS2, 32'h0000_0033);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("hold_rs2",  SEL_RS2,  32'h0000_0033);
        chk("hold_tv",   SEL_TV,   32'd0);
        chk("hold_trd",  SEL_TRD,  32'd9);
        chk("hold_tdat", SEL_TDAT, 32'h0000_0099);
        step();

        // Counter wrap
        force dut.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        exp_cnt = 32'hFFFF_FFFF;
        drive(1'b1, 5'd2, 32'h0000_0044);
        step();
        drive(1'b0, 5'd0, 32'd0);
        rf_if.dbg_addr = 5'd2;
        rf_if.rs1_addr = 5'd2;
        chk("wrap_cnt",  SEL_CNT,  32'd0);
        chk("wrap_tdat", SEL_TDAT, 32'h0000_0044);
        chk("wrap_dbg",  SEL_DBG,  32'h0000_0044);
        chk("wrap_rs1",  SEL_RS1,  32'h0000_0044);
        step();

        // Asynchronous reset mid-cycle after writing x5
        drive(1'b1, 5'd5, 32'h1234_5678);
        step();
        drive(1'b0, 5'd0, 32'd0);
        rf_if.rs1_addr = 5'd5;
        rf_if.dbg_addr = 5'd5;
        chk("pre_reset_rs1", SEL_RS1, 32'h1234_5678);
        step();
        #2;
        rst_n   = 1'b0;
        exp_cnt = 32'd0;
        #1;
        chk("async_rs1",  SEL_RS1,  32'd0);
        chk("async_dbg",  SEL_DBG,  32'd0);
        chk("async_cnt",  SEL_CNT,  32'd0);
        chk("async_tv",   SEL_TV,   32'd0);
        chk("async_tdat", SEL_TDAT, 32'd0);
        step();
        // Writes while reset is held must not commit (no trace booked)
        rf_if.reg_write = 1'b1;
        rf_if.rd_addr   = 5'd5;
        rf_if.wb_data   = 32'h5555_5555;
        chk("held_rs1", SEL_RS1, 32'd0);
        step();
        rf_if.reg_write = 1'b0;
        chk("held_rs1_after", SEL_RS1, 32'd0);
        chk("held_cnt",       SEL_CNT, 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 5'd6, 32'h0000_0066);
        step();
        drive(1'b0, 5'd0, 32'd0);
        rf_if.rs1_addr = 5'd6;
        chk("post_reset_rs1", SEL_RS1, 32'h0000_0066);
        chk("post_reset_cnt", SEL_CNT, 32'd1);
        step();
        step();

        tests++;
        if (tr_q.size() != 0) begin
            fails++;
            $display("FAIL trace_missing: got %0d pulses pending expected 0", tr_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32_regfile.md
# rv32_regfile

Architectural integer register file for the RV32I single-cycle core: the consumer of the writeback mux output. Captures `wb_data` into `x[rd]` on the rising clock edge, serves two combinational source-operand read ports plus a debug read port, and emits a one-cycle commit trace that benches use to check retired writes. `x0` is hardwired to zero.

## Interface
- `XLEN`, 32, data width of each register.
- `NREGS`, 32, number of architectural registers.
- `REG_ADDR_W`, 5, register index width (log2 of `NREGS`).

Ports:
- `clk`  in  1  system clock, rising-edge active.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `reg_write`  in  1  write enable from the control unit.
- `rd_addr`  in  `REG_ADDR_W`  destination register index.
- `wb_data`  in  `XLEN`  writeback value from the writeback mux.
- `rs1_addr`  in  `REG_ADDR_W`  source register 1 index.
- `rs2_addr`  in  `REG_ADDR_W`  source register 2 index.
- `rs1_data`  out  `XLEN`  source register 1 value, combinational.
- `rs2_data`  out  `XLEN`  source register 2 value, combinational.
- `dbg_addr`  in  `REG_ADDR_W`  debug read index.
- `dbg_data`  out  `XLEN`  debug read value, combinational, never bypassed.
- `trace_valid`  out  1  one-cycle pulse: a write committed at the last edge.
- `trace_rd`  out  `REG_ADDR_W`  index of the committed write.
- `trace_data`  out  `XLEN`  value of the committed write.
- `wr_count`  out  32  count of committed writes since reset.

## Operation
- A **commit** occurs at a rising edge when `reg_write=1` and `rd_addr!=0`. On a commit:
  - `x[rd_addr] <= wb_data`.
  - `trace_valid <= 1`, `trace_rd <= rd_addr`, `trace_data <= wb_data`.
  - `wr_count <= wr_count + 1`, modulo 2^32; it wraps from 0xFFFFFFFF to 0.
- In all other cycles:
  - `trace_valid <= 0`.
  - `trace_rd` and `trace_data` hold their previous values.
  - `wr_count` holds.
- A write to x0 (`reg_write=1`, `rd_addr=0`) is discarded entirely: no storage change, no trace pulse, no count.
- Reads:
  - A read with index 0 returns 0 on every port.
  - Any other read index returns the stored value, modified only by bypass (see Configuration).
- Index decoding uses the full `REG_ADDR_W` bits; with `NREGS=32` there are no out-of-range indices.

## Timing
- Write latency: one edge. A value presented with `reg_write` in cycle N is readable (without bypass) in cycle N+1.
- Read ports are purely combinational from address and storage; zero latency.
- Trace outputs are registered: they describe the commit at the immediately preceding edge.
- Reset:
  - Asynchronous assertion at `rst_n=0` forces all `x[i]=0`, `trace_valid=0`, `trace_rd=0`, `trace_data=0` and `wr_count=0` immediately, regardless of the clock.
  - While reset is held, no commits occur.
  - Deassertion is assumed synchronized upstream; the first commit can happen at the first rising edge after release.
- Reset mid-operation: a write pending in the cycle reset asserts is lost; `rs1_data`/`rs2_data` read 0 during reset.
- Simultaneous write and read of the same register: the result depends on `REGFILE_BYPASS_EN`.
- `rs1_addr == rs2_addr` is legal; both ports return the same value.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-through. When `reg_write=1`, `rd_addr!=0` and `rsX_addr==rd_addr`, `rsX_data` returns `wb_data` combinationally in the same cycle. `dbg_data` is never bypassed.
- `REGFILE_BYPASS_EN` undefined: reads always return the stored value, i.e. the old value during a same-cycle write. This is the default for the single-cycle core.

## Structure
- Shared package `rv32_pkg` holds `XLEN`, `REG_ADDR_W`, `NREGS`, `ZERO_REG` (5'd0) and the typedefs `reg_addr_t` and `xlen_t`; the writeback mux and decoder use the same definitions.
- One sub-module, `regfile_read_port`: address decode, zero-register forcing and the optional bypass mux.
  - Instantiated twice, for rs1 and rs2.
  - The debug port instantiates it with bypass tied off.
- Storage, commit logic, trace registers and counter live in the top.

## Test plan
- **Reset:** assert `rst_n=0` mid-cycle after writing x5=0x12345678 → `rs1_data` (rs1=5) reads 0 immediately; `wr_count=0`; `trace_valid=0`.
- **Basic write/read:** write x1=0xAAAAAAAA, x31=0xBBBBBBBB on consecutive edges → next cycle rs1=1 gives 0xAAAAAAAA, rs2=31 gives 0xBBBBBBBB; `trace_valid` pulses twice with rd 1 then 31; `wr_count=2`.
- **x0 discard:** `reg_write=1`, rd=0, `wb_data`=0xDEADBEEF → rs1=0 reads 0; `trace_valid` stays 0; `wr_count` unchanged.
- **Same-cycle read of the register being written:** x7=0x11111111, then in one cycle write x7=0x22222222 with rs1=7 → 0x22222222 with `REGFILE_BYPASS_EN`, 0x11111111 without; next cycle both builds read 0x22222222.
- **Hold:** `reg_write=0` with rd=3 and `wb_data`=0x44 → x3 unchanged; `trace_rd`/`trace_data` hold their last values; `trace_valid=0`.
- **Counter wrap:** force `wr_count`=0xFFFFFFFF, then commit x2=0x00000044 → `wr_count=0`; `trace_data`=0x00000044; `dbg_data` (dbg=2) reads 0x00000044.
